// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the instruction fetch front-end.
// Imported by the fetch queue top and its interface users.
package instr_fetch_queue_pkg;

    localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
    localparam int          WordSize       = 4;
    localparam logic [31:0] Nop            = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// IM read port, redirect input and decode handshake of the fetch queue.
// master = fetch queue side, slave = memory/decode side.
interface instr_fetch_queue_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);

    logic                 redirect_valid;
    logic [AddrWidth-1:0] redirect_addr;
    logic                 instr_read;
    logic [AddrWidth-1:0] instr_addr;
    logic [DataWidth-1:0] instr_out;
    logic                 deq_valid;
    logic [DataWidth-1:0] deq_instr;
    logic [AddrWidth-1:0] deq_pc;
    logic                 deq_ready;

    modport master (
        input  redirect_valid,
        input  redirect_addr,
        output instr_read,
        output instr_addr,
        input  instr_out,
        output deq_valid,
        output deq_instr,
        output deq_pc,
        input  deq_ready
    );

    modport slave (
        output redirect_valid,
        output redirect_addr,
        input  instr_read,
        input  instr_addr,
        output instr_out,
        input  deq_valid,
        input  deq_instr,
        input  deq_pc,
        output deq_ready
    );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the fetch queue.
// Head is read straight from the storage array; flush clears occupancy.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int Width = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] head,
    output logic [CW-1:0]    count
);

    logic [Width-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: sequential PC generation against a 1-cycle IM,
// credit-limited issue, redirect flush, FIFO hand-off to decode.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter logic [AddrWidth-1:0] ResetPC = AddrWidth'(ResetPcDefault)
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = AddrWidth + DataWidth;
    localparam logic [CW:0] DepthCnt = (CW + 1)'(DEPTH);

    logic [AddrWidth-1:0] fetch_pc;
    logic [AddrWidth-1:0] inflight_pc;
    logic                 inflight;
    logic [CW-1:0]        count;
    logic [CW:0]          occ;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [EW-1:0]        head;

    // A pop is not credited, so a response can never land in a full FIFO.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue = !bus.redirect_valid && (occ < DepthCnt);
    assign push  = inflight && !bus.redirect_valid;
    assign pop   = bus.deq_valid && bus.deq_ready && !bus.redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= ResetPC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_addr[AddrWidth-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + AddrWidth'(WordSize);
                inflight_pc <= fetch_pc;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .Width (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({inflight_pc, bus.instr_out}),
        .head  (head),
        .count (count)
    );

    assign bus.instr_read = issue;
    assign bus.instr_addr = fetch_pc;
    assign bus.deq_valid  = (count != '0);
    assign bus.deq_pc     = head[EW-1:DataWidth];
    assign bus.deq_instr  = head[DataWidth-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a PC scoreboard on the
// decode side and a one-cycle IM model returning a tagged address.
module tb_instr_fetch_queue;

    localparam logic [31:0] Tag = 32'hDEAD_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    logic [31:0] sb[$];

    instr_fetch_queue_if bus ();

    instr_fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.instr_out <= bus.instr_read ? (bus.instr_addr ^ Tag) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) begin
            sb.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshake observed mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.deq_valid && bus.deq_ready && !bus.redirect_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", bus.deq_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("deq_pc", bus.deq_pc, e);
                chk("deq_instr", bus.deq_instr, e ^ Tag);
            end
            pops++;
        end
    end

    initial begin
        int mark;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.deq_ready      = 1'b0;
        bus.instr_out      = '0;

        #1 rst = 1'b1;
        #1;
        chk("rst_read", bus.instr_read, 1);
        chk("rst_addr", bus.instr_addr, 32'h0);
        chk("rst_valid", bus.deq_valid, 0);
        chk("rst_pc", bus.deq_pc, 32'h0);
        chk("rst_instr", bus.deq_instr, 32'h0);
        #1 rst = 1'b0;
        expect_seq(32'h0, 64);
        bus.deq_ready = 1'b1;
        chk("start_addr", bus.instr_addr, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("seq_addr", bus.instr_addr, 32'(4 * k));
            chk("seq_valid", bus.deq_valid, (k >= 2) ? 1 : 0);
        end

        // Stall decode: queue fills to DEPTH, issue stops.
        bus.deq_ready = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        chk("full_read", bus.instr_read, 0);
        chk("full_valid", bus.deq_valid, 1);
        chk("full_head", bus.deq_pc, sb[0]);
        chk("full_depth", bus.instr_addr, sb[0] + 32'd16);

        // One pop, then stall: 3 queued + 1 in flight.
        bus.deq_ready = 1'b1;
        cyc();
        bus.deq_ready = 1'b0;
        chk("credit_read", bus.instr_read, 1);
        cyc();
        chk("credit_stop", bus.instr_read, 0);
        chk("credit_addr", bus.instr_addr, sb[0] + 32'd16);

        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0103;
        bus.deq_ready      = 1'b1;
        expect_seq(32'h100, 64);
        #1;
        chk("redir_noissue", bus.instr_read, 0);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("redir_flush", bus.deq_valid, 0);
        chk("redir_addr", bus.instr_addr, 32'h100);
        chk("redir_read", bus.instr_read, 1);
        cyc();
        chk("redir_v2", bus.deq_valid, 0);
        chk("redir_addr2", bus.instr_addr, 32'h104);
        cyc();
        chk("redir_v3", bus.deq_valid, 1);
        chk("redir_pc3", bus.deq_pc, 32'h100);
        for (int k = 0; k < 4; k++) cyc();

        // Back-to-back redirects: only the second target survives.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h200;
        expect_seq(32'h200, 64);
        cyc();
        bus.redirect_addr  = 32'h300;
        expect_seq(32'h300, 64);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("b2b_addr", bus.instr_addr, 32'h300);
        chk("b2b_valid", bus.deq_valid, 0);
        for (int k = 0; k < 6; k++) cyc();

        // Address wrap.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFF8;
        expect_seq(32'hFFFF_FFF8, 64);
        cyc();
        bus.redirect_valid = 1'b0;
        mark = pops;
        #1;
        chk("wrap_a0", bus.instr_addr, 32'hFFFF_FFF8);
        cyc();
        chk("wrap_a1", bus.instr_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_a2", bus.instr_addr, 32'h0000_0000);
        for (int k = 0; k < 5; k++) cyc();
        chk("wrap_pops", (pops - mark >= 3) ? 1 : 0, 1);

        // Asynchronous reset pulse between edges.
        #1 rst = 1'b1;
        #1;
        chk("arst_read", bus.instr_read, 1);
        chk("arst_addr", bus.instr_addr, 32'h0);
        chk("arst_valid", bus.deq_valid, 0);
        chk("arst_pc", bus.deq_pc, 32'h0);
        chk("arst_instr", bus.deq_instr, 32'h0);
        #1 rst = 1'b0;
        expect_seq(32'h0, 64);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("rseq_addr", bus.instr_addr, 32'(4 * k));
            chk("rseq_valid", bus.deq_valid, (k >= 2) ? 1 : 0);
        end
        cyc();
        chk("total_pops", (pops >= 20) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
